// File: rtl/async_fifo.sv
// Single-clock FIFO with wrap-bit pointers, registered read data and
// combinational full/empty flags derived from the pointer pair.
module async_fifo #(
  parameter int unsigned NUM_ADDRESS = 8,
  parameter int unsigned DATA_LENGTH = 32
) (
  input  logic                   w_clk,
  input  logic                   reset,
  input  logic                   w_en,
  input  logic                   r_en,
  input  logic [DATA_LENGTH-1:0] write_data,
  output logic [DATA_LENGTH-1:0] read_data,
  output logic                   fifo_full,
  output logic                   fifo_empty
);

  localparam int unsigned AddrW = $clog2(NUM_ADDRESS);
  localparam logic [AddrW:0] PtrOne = {{AddrW{1'b0}}, 1'b1};

  logic [DATA_LENGTH-1:0] mem_q [NUM_ADDRESS];
  logic [AddrW:0]         write_address_q, write_address_d;
  logic [AddrW:0]         read_address_q, read_address_d;
  logic [DATA_LENGTH-1:0] read_data_q, read_data_d;
  logic                   write_ok, read_ok;

  // MSB is the wrap bit: equal low bits with differing wrap bits means full.
  always_comb begin
    fifo_empty = (write_address_q == read_address_q);
    fifo_full  = (write_address_q[AddrW-1:0] == read_address_q[AddrW-1:0]) &&
                 (write_address_q[AddrW] != read_address_q[AddrW]);
    write_ok   = w_en && !fifo_full;
    read_ok    = r_en && !fifo_empty;
  end

  always_comb begin
    write_address_d = write_address_q;
    read_address_d  = read_address_q;
    read_data_d     = read_data_q;
    if (write_ok) begin
      write_address_d = write_address_q + PtrOne;
    end
    if (read_ok) begin
      read_address_d = read_address_q + PtrOne;
      read_data_d    = mem_q[read_address_q[AddrW-1:0]];
    end
  end

  always_ff @(posedge w_clk) begin
    if (reset) begin
      write_address_q <= '0;
      read_address_q  <= '0;
      read_data_q     <= '0;
    end else begin
      write_address_q <= write_address_d;
      read_address_q  <= read_address_d;
      read_data_q     <= read_data_d;
    end
  end

  // Storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge w_clk) begin
    if (!reset && write_ok) begin
      mem_q[write_address_q[AddrW-1:0]] <= write_data;
    end
  end

  assign read_data = read_data_q;

endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo: drives on the falling edge, checks 1 time
// unit after each rising edge against hand-computed values.
module tb_async_fifo;

  logic        w_clk = 1'b0;
  logic        reset;
  logic        w_en;
  logic        r_en;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        fifo_full;
  logic        fifo_empty;

  int total = 0;
  int bad   = 0;

  async_fifo #(
    .NUM_ADDRESS(8),
    .DATA_LENGTH(32)
  ) dut (
    .w_clk     (w_clk),
    .reset     (reset),
    .w_en      (w_en),
    .r_en      (r_en),
    .write_data(write_data),
    .read_data (read_data),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty)
  );

  always #5 w_clk = ~w_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given inputs, leaving time just past the edge.
  task automatic step(input logic rst, input logic we, input logic re, input logic [31:0] d);
    @(negedge w_clk);
    reset      = rst;
    w_en       = we;
    r_en       = re;
    write_data = d;
    @(posedge w_clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic full, input logic empty);
    check({tag, "_full"}, {31'd0, fifo_full}, {31'd0, full});
    check({tag, "_empty"}, {31'd0, fifo_empty}, {31'd0, empty});
  endtask

  initial begin
    reset = 1'b1; w_en = 1'b0; r_en = 1'b0; write_data = '0;

    // 1: reset two cycles (with w_en high to show reset wins), then release
    step(1'b1, 1'b1, 1'b0, 32'h1111_1111);
    step(1'b1, 1'b1, 1'b0, 32'h1111_1111);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("rst_rdata", read_data, 32'h0);
    check_flags("rst", 1'b0, 1'b1);
    check("rst_wptr", {28'd0, dut.write_address_q}, 32'd0);
    check("rst_rptr", {28'd0, dut.read_address_q}, 32'd0);

    // 2: two writes, two reads
    step(1'b0, 1'b1, 1'b0, 32'hA5A5_A5A5);
    check_flags("w1", 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'hDEAD_BABE);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    check("r1", read_data, 32'hA5A5_A5A5);
    check_flags("r1", 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    check("r2", read_data, 32'hDEAD_BABE);
    check_flags("r2", 1'b0, 1'b1);

    // 3: two writes, four reads; extra reads are ignored
    step(1'b0, 1'b1, 1'b0, 32'hDEAD_FADE);
    step(1'b0, 1'b1, 1'b0, 32'hFADE_D000);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    check("t3_r1", read_data, 32'hDEAD_FADE);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    check("t3_r2", read_data, 32'hFADE_D000);
    check_flags("t3_r2", 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    check("t3_hold", read_data, 32'hFADE_D000);
    check("t3_rptr", {28'd0, dut.read_address_q}, 32'd4);
    check("t3_wptr", {28'd0, dut.write_address_q}, 32'd4);

    // 4: 12 writes of FADEFADE; full after the 8th, rest dropped
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'hFADE_FADE);
      if (i == 7) check_flags("t4_w7", 1'b0, 1'b0);
      if (i == 8) check_flags("t4_w8", 1'b1, 1'b0);
    end
    check_flags("t4_w12", 1'b1, 1'b0);
    check("t4_wptr", {28'd0, dut.write_address_q}, 32'd12);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'h0);
      check("t4_rd", read_data, 32'hFADE_FADE);
    end
    check_flags("t4_drained", 1'b0, 1'b1);
    check("t4_rptr", {28'd0, dut.read_address_q}, 32'd12);

    // 5a: fill with distinct words, then read+write while full
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 32'h100 + i);
    check_flags("t5_fill", 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0BAD);
    check("t5_full_rw", read_data, 32'h100);
    check_flags("t5_full_rw", 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'h0);
      check("t5_drain", read_data, 32'h100 + i);
    end
    check_flags("t5_drained", 1'b0, 1'b1);

    // 5b: read+write while empty: write lands, read ignored
    step(1'b0, 1'b1, 1'b1, 32'h77);
    check("t5_empty_rw", read_data, 32'h107);
    check_flags("t5_empty_rw", 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    check("t5_rd77", read_data, 32'h77);
    check_flags("t5_rd77", 1'b0, 1'b1);

    // 6: reset with 5 words stored
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 32'h200 + i);
    check_flags("t6_5w", 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h0);
    check("t6_rst_rdata", read_data, 32'h0);
    check_flags("t6_rst", 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h55);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    check("t6_new", read_data, 32'h55);
    check_flags("t6_new", 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
